// File: rtl/placar_pkg.sv
// Shared types and constants for the per-team BCD score register.
package placar_pkg;
  typedef enum logic [1:0] {IDLE, UP, DOWN} placar_state_t;
  typedef logic [3:0] bcd_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int PTS_W = 2;
endpackage

// File: rtl/bcd_digit_updn.sv
// One BCD digit counter with inc/dec enables; carry/borrow feed the next digit.
module bcd_digit_updn
  import placar_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output bcd_t q,
  output logic carry_out,
  output logic borrow_out
);
  assign carry_out  = inc && (q == BCD_MAX);
  assign borrow_out = dec && (q == 4'd0);

  always_ff @(posedge clk) begin
    if (reset || clr)
      q <= 4'd0;
    else if (inc)
      q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
    else if (dec)
      q <= (q == 4'd0) ? BCD_MAX : q - 4'd1;
  end
endmodule

// File: rtl/placar_bcd.sv
// Score register: button edges drive a sequencer that steps a 3-digit BCD
// score one point per clock, saturating at 000 and 999.
//   state | meaning
//   IDLE  | waiting for a button edge
//   UP    | adding one point per cycle until rem is exhausted or 999
//   DOWN  | single-cycle correction, stops at 000
module placar_bcd
  import placar_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic btn_p1,
  input  logic btn_p2,
  input  logic btn_p3,
  input  logic btn_sub,
  input  logic btn_clr,
  output bcd_t dig0,
  output bcd_t dig1,
  output bcd_t dig2,
  output logic busy
);
  placar_state_t    state;
  logic [PTS_W-1:0] rem;
  logic [3:0]       prev;
  logic [3:0]       btns;
  logic [3:0]       edges;
  logic             sat, zero, step_up, step_dn;
  logic             c0, c1, b0, b1, carry_unused, borrow_unused;

  assign btns    = {btn_sub, btn_p3, btn_p2, btn_p1};
  assign edges   = btns & ~prev;
  assign sat     = (dig2 == BCD_MAX) && (dig1 == BCD_MAX) && (dig0 == BCD_MAX);
  assign zero    = (dig2 == 4'd0) && (dig1 == 4'd0) && (dig0 == 4'd0);
  assign step_up = (state == UP) && !sat;
  assign step_dn = (state == DOWN) && !zero;

  bcd_digit_updn u_d0 (
    .clk(clk), .reset(reset), .clr(btn_clr), .inc(step_up), .dec(step_dn),
    .q(dig0), .carry_out(c0), .borrow_out(b0)
  );
  bcd_digit_updn u_d1 (
    .clk(clk), .reset(reset), .clr(btn_clr), .inc(c0), .dec(b0),
    .q(dig1), .carry_out(c1), .borrow_out(b1)
  );
  bcd_digit_updn u_d2 (
    .clk(clk), .reset(reset), .clr(btn_clr), .inc(c1), .dec(b1),
    .q(dig2), .carry_out(carry_unused), .borrow_out(borrow_unused)
  );

  // prev resets high so a button held through reset release never fires
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rem   <= '0;
      prev  <= 4'b1111;
      busy  <= 1'b0;
    end else begin
      prev <= btns;
      if (btn_clr) begin
        state <= IDLE;
        rem   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (edges[3]) begin
              state <= DOWN; rem <= PTS_W'(1); busy <= 1'b1;
            end else if (edges[2]) begin
              state <= UP; rem <= PTS_W'(3); busy <= 1'b1;
            end else if (edges[1]) begin
              state <= UP; rem <= PTS_W'(2); busy <= 1'b1;
            end else if (edges[0]) begin
              state <= UP; rem <= PTS_W'(1); busy <= 1'b1;
            end
          end
          UP: begin
            if (sat || rem == PTS_W'(1)) begin
              state <= IDLE; rem <= '0; busy <= 1'b0;
            end else begin
              rem <= rem - PTS_W'(1);
            end
          end
          DOWN: begin
            state <= IDLE; rem <= '0; busy <= 1'b0;
          end
          default: begin
            state <= IDLE; rem <= '0; busy <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_placar_bcd.sv
// Scoreboard bench for placar_bcd: expected digit/busy traces are queued by
// the stimulus and checked by a monitor on every busy (and busy-falling) cycle.
module tb_placar_bcd;
  import placar_pkg::*;

  logic clk = 1'b0;
  logic reset, btn_p1, btn_p2, btn_p3, btn_sub, btn_clr;
  bcd_t dig0, dig1, dig2;
  logic busy;

  typedef struct packed {
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
    logic       b;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   score = 0;
  logic mon_prev_busy = 1'b0;

  placar_bcd dut (
    .clk(clk), .reset(reset), .btn_p1(btn_p1), .btn_p2(btn_p2), .btn_p3(btn_p3),
    .btn_sub(btn_sub), .btn_clr(btn_clr), .dig0(dig0), .dig1(dig1), .dig2(dig2),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input int v, input logic b);
    exp_t e;
    e.d2 = 4'(v / 100);
    e.d1 = 4'((v / 10) % 10);
    e.d0 = 4'(v % 10);
    e.b  = b;
    return e;
  endfunction

  task automatic push(input int v, input logic b);
    exp_q.push_back(mk(v, b));
  endtask

  // monitor: fires while busy and on the cycle busy falls
  always @(negedge clk) begin
    exp_t e;
    if (busy || mon_prev_busy) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: got %0d%0d%0d busy=%0b, required no activity",
                 dig2, dig1, dig0, busy);
      end else begin
        e = exp_q.pop_front();
        if (e.d2 !== dig2 || e.d1 !== dig1 || e.d0 !== dig0 || e.b !== busy) begin
          n_bad++;
          $display("FAIL trace: got %0d%0d%0d busy=%0b, required %0d%0d%0d busy=%0b",
                   dig2, dig1, dig0, busy, e.d2, e.d1, e.d0, e.b);
        end
      end
    end
    mon_prev_busy = busy;
  end

  task automatic set_btn(input int which, input logic v);
    case (which)
      1: btn_p1 = v;
      2: btn_p2 = v;
      3: btn_p3 = v;
      default: btn_sub = v;
    endcase
  endtask

  task automatic press(input int which);
    @(posedge clk); #1; set_btn(which, 1'b1);
    @(posedge clk); #1; set_btn(which, 1'b0);
  endtask

  // model-driven press used only to walk the score to a starting value
  task automatic model_press(input int which);
    int s, l, nv;
    if (which == 4) begin
      push(score, 1'b1);
      nv = (score > 0) ? score - 1 : 0;
      push(nv, 1'b0);
    end else begin
      s = (which < 999 - score) ? which : 999 - score;
      l = (s == which) ? which : s + 1;
      for (int j = 0; j < l; j++) push(score + ((j < s) ? j : s), 1'b1);
      nv = score + s;
      push(nv, 1'b0);
    end
    score = nv;
    press(which);
    repeat (5) @(posedge clk);
  endtask

  task automatic bring_to(input int target);
    @(posedge clk); #1; btn_clr = 1'b1;
    @(posedge clk); #1; btn_clr = 1'b0;
    score = 0;
    while (score + 3 <= target) model_press(3);
    while (score < target) model_press(1);
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
  endtask

  initial begin
    reset = 1'b1; btn_p1 = 1'b1; btn_p2 = 1'b0; btn_p3 = 1'b0;
    btn_sub = 1'b0; btn_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (dig2 !== 4'd0 || dig1 !== 4'd0 || dig0 !== 4'd0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got %0d%0d%0d busy=%0b, required 000 busy=0",
               dig2, dig1, dig0, busy);
    end
    // p1 held through reset release must not count
    @(posedge clk); #1; reset = 1'b0;
    repeat (4) @(posedge clk); #1; btn_p1 = 1'b0;
    settle();

    // +3 from 000
    push(0, 1); push(1, 1); push(2, 1); push(3, 0);
    press(3); settle(); score = 3;

    // 098 +3 carries across two digits
    bring_to(98);
    push(98, 1); push(99, 1); push(100, 1); push(101, 0);
    press(3); settle(); score = 101;

    // 998 +3 saturates at 999 after two busy cycles
    bring_to(998);
    push(998, 1); push(999, 1); push(999, 0);
    press(3); settle(); score = 999;

    // sub at 000 stays 000; sub at 100 borrows to 099
    bring_to(0);
    push(0, 1); push(0, 0);
    press(4); settle();
    bring_to(100);
    push(100, 1); push(99, 0);
    press(4); settle(); score = 99;

    // p2 and sub together at 050: only sub applies
    bring_to(50);
    push(50, 1); push(49, 0);
    @(posedge clk); #1; btn_p2 = 1'b1; btn_sub = 1'b1;
    @(posedge clk); #1; btn_p2 = 1'b0; btn_sub = 1'b0;
    settle(); score = 49;

    // p1 rising during busy and then held is ignored
    push(49, 1); push(50, 1); push(51, 1); push(52, 0);
    @(posedge clk); #1; btn_p3 = 1'b1;
    @(posedge clk); #1; btn_p3 = 1'b0;
    @(posedge clk); #1; btn_p1 = 1'b1;
    repeat (10) @(posedge clk); #1; btn_p1 = 1'b0;
    settle(); score = 52;

    // clr mid +3 at 037
    bring_to(37);
    push(37, 1); push(38, 1); push(0, 0);
    @(posedge clk); #1; btn_p3 = 1'b1;
    @(posedge clk); #1; btn_p3 = 1'b0;
    @(posedge clk); #1; btn_clr = 1'b1;
    @(posedge clk); #1; btn_clr = 1'b0;
    settle(); score = 0;

    // reset mid +3 at 037
    bring_to(37);
    push(37, 1); push(38, 1); push(0, 0);
    @(posedge clk); #1; btn_p3 = 1'b1;
    @(posedge clk); #1; btn_p3 = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    settle(); score = 0;

    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: got %0d pending entries, required 0", exp_q.size());
    end
    n_cmp++;
    if (dig2 !== 4'd0 || dig1 !== 4'd0 || dig0 !== 4'd0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL final_state: got %0d%0d%0d busy=%0b, required 000 busy=0",
               dig2, dig1, dig0, busy);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/placar_bcd.md
# placar_bcd

Per-team score register for the basketball scoreboard: turns debounced point buttons (+1, +2, +3, −1 correction, clear) into a 3-digit BCD score. The score is updated one point per clock by a small sequencer. It sits directly upstream of the BCD-to-7-segment decoders: each output digit drives one decoder's 4-bit BCD input. Two instances (home/away) exist at scoreboard top level.

## Interface
- Parameters: none; width fixed at 3 BCD digits (score range 000–999).
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  synchronous, active-high reset
- `btn_p1`  in  1  +1 point request, level, active-high, already debounced and synchronous to `clk`
- `btn_p2`  in  1  +2 points request, same rules
- `btn_p3`  in  1  +3 points request, same rules
- `btn_sub`  in  1  −1 correction request, same rules
- `btn_clr`  in  1  clear score, level, active-high
- `dig0`  out  4  units BCD digit (0–9)
- `dig1`  out  4  tens BCD digit
- `dig2`  out  4  hundreds BCD digit
- `busy`  out  1  high while the sequencer is applying a request

## Operation
- Rising-edge detect on `btn_p1/p2/p3/btn_sub`: one previous-value register per button; an edge is `btn & ~prev`. Held buttons never retrigger.
- States: IDLE, UP, DOWN.
- IDLE, edge priority when several occur together: `btn_sub` > `btn_p3` > `btn_p2` > `btn_p1`. Lower-priority edges in that cycle are discarded.
- IDLE + p-edge: load `rem` = 1/2/3 and go to UP. IDLE + sub-edge: load `rem` = 1 and go to DOWN.
- UP, each cycle: add 1 to the score (BCD carry units→tens→hundreds) and decrement `rem`. Return to IDLE on the cycle where `rem` reaches 0.
- UP, score already 999: no increment, immediate return to IDLE; remaining points are dropped (saturate, never wrap).
- DOWN: subtract 1 with BCD borrow, then return to IDLE. If the score is 000, no change and return to IDLE (no wrap to 999).
- Edges arriving while not IDLE are discarded. The prev registers still track, so a button held across the busy window does not fire later.
- `btn_clr` (level): overrides everything in any state. Score ← 000, state ← IDLE, `rem` ← 0 on that edge.
- Digits never leave 0–9. All arithmetic is per-digit BCD, not binary with later conversion.

## Timing
- Reset values: `dig0`=`dig1`=`dig2`=0, `busy`=0, state IDLE, `rem`=0. All prev registers = 1, so a button held through reset release does not count.
- Request sampled at edge t (btn=1, prev=0): state ← UP/DOWN at t. Score changes at edges t+1 … t+k (k = points). State returns to IDLE at edge t+k.
- `busy` is high for exactly k cycles (1 cycle for sub), from after edge t until after edge t+k. Next request is accepted at edge t+k+1 at the earliest.
- Outputs are registered, with no combinational path from buttons to digits or `busy`.
- `reset` or `btn_clr` mid-sequence: takes effect at that edge. The in-flight remainder is lost.

## Structure
- Package `placar_pkg`:
  - state enum `placar_state_t` (IDLE, UP, DOWN)
  - constants `BCD_MAX` = 4'd9 and `PTS_W` = 2
  - 7-segment decoder digit type `bcd_t` = 4-bit
- Sub-module `bcd_digit_updn`: one BCD digit with `inc`/`dec` enables, `carry_out` (9→0 on inc), `borrow_out` (0→9 on dec), synchronous reset/clear. Instantiate ×3, chained; saturation is decided in the parent.

## Test plan
- Reset, then +3 pulse at 000 → `busy` high 3 cycles; digits step 001, 002, 003; final `dig2,dig1,dig0` = 0,0,3.
- Score 098, +3 → 099, 100, 101; carry across two digits is correct, final 1,0,1.
- Score 998, +3 → 999 then saturate; `busy` drops after 2 cycles; final 9,9,9.
- Score 000, `btn_sub` edge → score stays 000, `busy` high 1 cycle. Score 100, sub → 0,9,9.
- `btn_p2` and `btn_sub` rise in the same cycle at 050 → only sub applied, result 049. `btn_p1` edge during `busy` → ignored; holding it afterwards causes no increment.
- Score 037 mid +3 (after first step, 038), assert `btn_clr` 1 cycle → 000, `busy` 0 next cycle. Same scenario with `reset` → identical result.
